// File: rtl/regfile_port_scheduler_if.sv
// Request/grant bundle between the writeback/read requesters and the scheduler,
// plus the register-file facing write port and read-slot indication.
// Requesters drive through the master modport; the scheduler uses the slave modport.
interface regfile_port_scheduler_if;
    // ALU writeback requester
    logic        alu_req;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        alu_gnt;

    // Load writeback requester
    logic        mem_req;
    logic [4:0]  mem_reg;
    logic [31:0] mem_data;
    logic        mem_gnt;

    // Operand-read stage
    logic        rd_req;
    logic        rd_gnt;

    // Register-file write port and read-slot indication
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData_reg;
    logic        rd_valid;

    modport master (
        output alu_req, alu_reg, alu_data,
        input  alu_gnt,
        output mem_req, mem_reg, mem_data,
        input  mem_gnt,
        output rd_req,
        input  rd_gnt,
        input  RegWrite, WriteRegister, WriteData_reg, rd_valid
    );

    modport slave (
        input  alu_req, alu_reg, alu_data,
        output alu_gnt,
        input  mem_req, mem_reg, mem_data,
        output mem_gnt,
        input  rd_req,
        output rd_gnt,
        output RegWrite, WriteRegister, WriteData_reg, rd_valid
    );
endinterface

// File: rtl/regfile_port_scheduler.sv
// Shares the register file's single write port and read-update slot among ALU, load and read stage.
// Latency: grant is combinational (0 cycles); write/read slot is issued on the next edge (1 cycle).
// Backpressure: a requester holds req/reg/data until its gnt; reads win after MAX_WR_BURST writes.
module regfile_port_scheduler #(
    parameter int MAX_WR_BURST = 4
) (
    input logic                      clk,
    input logic                      reset,
    regfile_port_scheduler_if.slave  bus
);

    // Counter must be able to hold MAX_WR_BURST itself.
    localparam int              BW      = $clog2(MAX_WR_BURST + 1);
    localparam logic [BW-1:0]   MAX_CNT = BW'(MAX_WR_BURST);

    // Which requester owns the port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_MEM  = 2'd2,
        GNT_RD   = 2'd3
    } gnt_e;

    // Arbitration state: last write winner (0 = ALU, 1 = MEM) and consecutive write count.
    logic           r_rr_last;
    logic [BW-1:0]  r_burst_cnt;

    // Registered register-file interface.
    logic           r_reg_write;
    logic [4:0]     r_write_register;
    logic [31:0]    r_write_data;
    logic           r_rd_valid;

    // Combinational arbitration results.
    gnt_e           w_sel;
    logic           w_any_wr;
    logic           w_burst_full;

    assign w_any_wr     = bus.alu_req | bus.mem_req;
    assign w_burst_full = (r_burst_cnt == MAX_CNT);

    // Pick the owner of this cycle: a pending read pre-empts writes only once the
    // write burst has reached its limit (or when no write is asking), otherwise the
    // single write requester wins, and a write tie goes to whoever did not win last.
    // Nothing is granted while reset is held.
    always_comb begin
        w_sel = GNT_NONE;
        if (reset) begin
            w_sel = GNT_NONE;
        end else if (bus.rd_req && (w_burst_full || !w_any_wr)) begin
            w_sel = GNT_RD;
        end else if (bus.alu_req && !bus.mem_req) begin
            w_sel = GNT_ALU;
        end else if (bus.mem_req && !bus.alu_req) begin
            w_sel = GNT_MEM;
        end else if (bus.alu_req && bus.mem_req) begin
            w_sel = r_rr_last ? GNT_ALU : GNT_MEM;
        end else begin
            w_sel = GNT_NONE;
        end
    end

    assign bus.alu_gnt = (w_sel == GNT_ALU);
    assign bus.mem_gnt = (w_sel == GNT_MEM);
    assign bus.rd_gnt  = (w_sel == GNT_RD);

    // Issue the granted operation to the register file one edge after the grant;
    // address/data keep their last value on non-write cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reg_write      <= 1'b0;
            r_write_register <= 5'd0;
            r_write_data     <= 32'd0;
            r_rd_valid       <= 1'b0;
        end else begin
            case (w_sel)
                GNT_ALU: begin
                    r_reg_write      <= 1'b1;
                    r_write_register <= bus.alu_reg;
                    r_write_data     <= bus.alu_data;
                    r_rd_valid       <= 1'b0;
                end
                GNT_MEM: begin
                    r_reg_write      <= 1'b1;
                    r_write_register <= bus.mem_reg;
                    r_write_data     <= bus.mem_data;
                    r_rd_valid       <= 1'b0;
                end
                GNT_RD: begin
                    r_reg_write      <= 1'b0;
                    r_rd_valid       <= 1'b1;
                end
                default: begin
                    r_reg_write      <= 1'b0;
                    r_rd_valid       <= 1'b0;
                end
            endcase
        end
    end

    // Remember the last write winner so a tie alternates; reset favours the ALU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_last <= 1'b1;
        end else if (w_sel == GNT_ALU) begin
            r_rr_last <= 1'b0;
        end else if (w_sel == GNT_MEM) begin
            r_rr_last <= 1'b1;
        end
    end

    // Count back-to-back write grants, saturating, and clear on any non-write cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_burst_cnt <= '0;
        end else if ((w_sel == GNT_ALU) || (w_sel == GNT_MEM)) begin
            if (!w_burst_full) begin
                r_burst_cnt <= r_burst_cnt + 1'b1;
            end
        end else begin
            r_burst_cnt <= '0;
        end
    end

    assign bus.RegWrite      = r_reg_write;
    assign bus.WriteRegister = r_write_register;
    assign bus.WriteData_reg = r_write_data;
    assign bus.rd_valid      = r_rd_valid;

endmodule
